// File: rtl/bp_pkg.sv
// Shared types for the fetch redirect controller.
//   addr_t        : full-width PC / target
//   pred_entry_t  : one tracked prediction {pred_jump, pred_target}
//   fsm_t         : fetch sequencer states
//   PC_INC        : sequential fetch increment
package bp_pkg;
  localparam int unsigned ADDR_W = 64;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic  pred_jump;
    addr_t pred_target;
  } pred_entry_t;

  typedef enum logic [1:0] {RUN, HOLD, RECOVER} fsm_t;

  localparam addr_t PC_INC = 64'd4;
endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Pipeline-side bundle of the fetch redirect controller.
//   master : controller view (drives fetch PC, redirect, flush, BTB update, status)
//   slave  : pipeline/BTB view (drives stall, BTB prediction, EXE resolution)
interface fetch_redirect_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 64
);
  logic                  stall;
  logic [ADDR_WIDTH-1:0] pc_if;
  logic                  if_valid;
  logic                  bp_jump_if;
  logic [ADDR_WIDTH-1:0] bp_target_if;
  logic                  exe_valid;
  logic [ADDR_WIDTH-1:0] pc_exe;
  logic                  is_jump_exe;
  logic                  jump_exe;
  logic [ADDR_WIDTH-1:0] pc_target_exe;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  flush;
  logic                  btb_update;
  logic                  tracker_full;
  logic                  trk_underflow;
  logic [31:0]           perf_branches;
  logic [31:0]           perf_mispred;

  modport master (
    input  stall, bp_jump_if, bp_target_if, exe_valid, pc_exe, is_jump_exe,
           jump_exe, pc_target_exe,
    output pc_if, if_valid, redirect, redirect_pc, flush, btb_update,
           tracker_full, trk_underflow, perf_branches, perf_mispred
  );

  modport slave (
    output stall, bp_jump_if, bp_target_if, exe_valid, pc_exe, is_jump_exe,
           jump_exe, pc_target_exe,
    input  pc_if, if_valid, redirect, redirect_pc, flush, btb_update,
           tracker_full, trk_underflow, perf_branches, perf_mispred
  );
endinterface

// File: rtl/fetch_redirect_ctrl_pred_tracker_fifo.sv
// pred_tracker_fifo: circular buffer of in-flight predictions.
//   clk, rst (async, active-high), push/pop/clear controls, din entry,
//   head (zero when empty), count, full, empty.
// Push on full and pop on empty are ignored; DEPTH must be a power of 2.
module pred_tracker_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  pred_entry_t              din,
  output pred_entry_t              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned PW = $clog2(DEPTH);

  pred_entry_t   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: owns the IF PC, chooses BTB target or PC+4, tracks each
// prediction until EXE, and raises redirect/flush on a mispredict.
//   clk, rst : clock, async active-high reset
//   bus      : fetch_redirect_ctrl_if.master (stall, BTB lookup, EXE resolution,
//              redirect/flush/btb_update, tracker status, perf counters)
// Optional: define BP_PERF_CNT_EN to build the saturating perf counters;
// otherwise perf_branches/perf_mispred are tied to 0.
module fetch_redirect_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 64,
  parameter int unsigned           INFLIGHT    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           RECOVER_CYC = 1
) (
  input logic                  clk,
  input logic                  rst,
  fetch_redirect_ctrl_if.master bus
);
  localparam int unsigned CW = $clog2(INFLIGHT);
  localparam int unsigned RW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

  typedef logic [ADDR_WIDTH-1:0] pc_t;

  fsm_t        state, state_nxt;
  pc_t         pc, pc_nxt, pred_tgt, correct_pc;
  logic [RW-1:0] rcnt, rcnt_nxt;
  logic [CW:0] count, count_nxt;
  logic        fetch, push, pop, mispredict, full, empty, underflow, btb_upd;
  pred_entry_t head, din;

  pred_tracker_fifo #(.DEPTH(INFLIGHT)) u_trk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (mispredict),
    .din   (din),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign fetch    = (state == RUN);
  assign pop      = bus.exe_valid & ~bus.stall;
  assign push     = fetch & ~bus.stall & ~mispredict;
  assign pred_tgt = head.pred_target[ADDR_WIDTH-1:0];
  assign btb_upd  = bus.exe_valid & bus.is_jump_exe & ~bus.stall;

  // Count as it will be after this cycle's push/pop; drives HOLD entry/exit.
  assign count_nxt = count + (CW+1)'(push) - (CW+1)'(pop & ~empty);

  always_comb begin
    din             = '0;
    din.pred_jump   = bus.bp_jump_if;
    din.pred_target = addr_t'(bus.bp_target_if);
  end

  always_comb begin
    mispredict = pop & (
        (bus.is_jump_exe & (bus.jump_exe != head.pred_jump))
      | (bus.is_jump_exe & bus.jump_exe & head.pred_jump & (pred_tgt != bus.pc_target_exe))
      | (~bus.is_jump_exe & head.pred_jump));
    correct_pc = (bus.is_jump_exe & bus.jump_exe) ? bus.pc_target_exe
                                                  : bus.pc_exe + ADDR_WIDTH'(PC_INC);
  end

  // Stall gates the registers, so next-state logic ignores it.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    rcnt_nxt  = rcnt;
    if (mispredict) begin
      state_nxt = RECOVER;
      pc_nxt    = correct_pc;
      rcnt_nxt  = RW'(RECOVER_CYC - 1);
    end else begin
      unique case (state)
        RUN: begin
          pc_nxt = bus.bp_jump_if ? bus.bp_target_if : pc + ADDR_WIDTH'(PC_INC);
          if (count_nxt == (CW+1)'(INFLIGHT)) state_nxt = HOLD;
        end
        HOLD: begin
          if (count_nxt < (CW+1)'(INFLIGHT)) state_nxt = RUN;
        end
        RECOVER: begin
          if (rcnt == '0) state_nxt = RUN;
          else            rcnt_nxt  = rcnt - RW'(1);
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      pc        <= RESET_PC;
      rcnt      <= '0;
      underflow <= 1'b0;
    end else if (!bus.stall) begin
      state <= state_nxt;
      pc    <= pc_nxt;
      rcnt  <= rcnt_nxt;
      if (pop & empty) underflow <= 1'b1;
    end
  end

  assign bus.pc_if         = pc;
  assign bus.if_valid      = fetch;
  assign bus.redirect      = mispredict;
  assign bus.flush         = mispredict;
  assign bus.redirect_pc   = mispredict ? correct_pc : '0;
  assign bus.btb_update    = btb_upd;
  assign bus.tracker_full  = full;
  assign bus.trk_underflow = underflow;

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_br, perf_mp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br <= '0;
      perf_mp <= '0;
    end else begin
      if (btb_upd && perf_br != '1)    perf_br <= perf_br + 32'd1;
      if (mispredict && perf_mp != '1) perf_mp <= perf_mp + 32'd1;
    end
  end

  assign bus.perf_branches = perf_br;
  assign bus.perf_mispred  = perf_mp;
`else
  assign bus.perf_branches = '0;
  assign bus.perf_mispred  = '0;
`endif
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: directed scenarios followed by
// randomized traffic, all compared each cycle against a queue-based model.
module tb_fetch_redirect_ctrl;
  localparam int unsigned AW    = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RCY   = 2;
  localparam logic [63:0] RPC   = 64'h1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_redirect_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fetch_redirect_ctrl #(
    .ADDR_WIDTH  (AW),
    .INFLIGHT    (DEPTH),
    .RESET_PC    (RPC),
    .RECOVER_CYC (RCY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: predictions in flight as a queue, fetch mode as a small
  // integer (0 fetching, 1 waiting for tracker room, 2 recovery bubbles).
  typedef struct {
    bit          pj;
    logic [63:0] pt;
  } pred_t;

  pred_t       q[$];
  logic [63:0] m_pc;
  int          m_mode;
  int          m_bub;
  bit          m_unf;
  logic [31:0] m_pb, m_pm;

  task automatic step();
    pred_t       h;
    bit          fetch, pop, mis, bupd;
    logic [63:0] cpc;
    fetch = (m_mode == 0);
    pop   = bus.exe_valid && !bus.stall;
    if (q.size() > 0) h = q[0];
    else              h = '{pj: 1'b0, pt: 64'd0};
    mis = pop && ((bus.is_jump_exe && (bus.jump_exe != h.pj)) ||
                  (bus.is_jump_exe && bus.jump_exe && h.pj && (h.pt != bus.pc_target_exe)) ||
                  (!bus.is_jump_exe && h.pj));
    cpc  = (bus.is_jump_exe && bus.jump_exe) ? bus.pc_target_exe : bus.pc_exe + 64'd4;
    bupd = bus.exe_valid && bus.is_jump_exe && !bus.stall;
    #3;
    chk("pc_if",         bus.pc_if,         m_pc);
    chk("if_valid",      bus.if_valid,      64'(fetch));
    chk("redirect",      bus.redirect,      64'(mis));
    chk("redirect_pc",   bus.redirect_pc,   mis ? cpc : 64'd0);
    chk("flush",         bus.flush,         64'(mis));
    chk("btb_update",    bus.btb_update,    64'(bupd));
    chk("tracker_full",  bus.tracker_full,  64'(q.size() == DEPTH));
    chk("trk_underflow", bus.trk_underflow, 64'(m_unf));
`ifdef BP_PERF_CNT_EN
    chk("perf_branches", bus.perf_branches, 64'(m_pb));
    chk("perf_mispred",  bus.perf_mispred,  64'(m_pm));
`else
    chk("perf_branches", bus.perf_branches, 64'd0);
    chk("perf_mispred",  bus.perf_mispred,  64'd0);
`endif
    @(posedge clk);
    if (!bus.stall) begin
      if (pop && q.size() == 0) m_unf = 1'b1;
      if (bupd && m_pb != '1) m_pb++;
      if (mis && m_pm != '1)  m_pm++;
      if (mis) begin
        q.delete();
        m_pc   = cpc;
        m_mode = 2;
        m_bub  = RCY - 1;
      end else begin
        if (pop && q.size() > 0) void'(q.pop_front());
        if (fetch) begin
          q.push_back('{pj: bus.bp_jump_if, pt: bus.bp_target_if});
          m_pc = bus.bp_jump_if ? bus.bp_target_if : m_pc + 64'd4;
        end
        case (m_mode)
          0:       if (q.size() == DEPTH) m_mode = 1;
          1:       if (q.size() < DEPTH)  m_mode = 0;
          default: if (m_bub == 0) m_mode = 0; else m_bub--;
        endcase
      end
    end
    #1;
  endtask

  task automatic drv(bit st, bit ev, logic [63:0] px, bit isj, bit j,
                     logic [63:0] tg, bit bj, logic [63:0] bt);
    bus.stall         = st;
    bus.exe_valid     = ev;
    bus.pc_exe        = px;
    bus.is_jump_exe   = isj;
    bus.jump_exe      = j;
    bus.pc_target_exe = tg;
    bus.bp_jump_if    = bj;
    bus.bp_target_if  = bt;
    step();
  endtask

  initial begin
    bus.stall = 0; bus.exe_valid = 0; bus.pc_exe = '0; bus.is_jump_exe = 0;
    bus.jump_exe = 0; bus.pc_target_exe = '0; bus.bp_jump_if = 0; bus.bp_target_if = '0;
    m_pc = RPC; m_mode = 0; m_bub = 0; m_unf = 0; m_pb = '0; m_pm = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_pc",        bus.pc_if,         RPC);
    chk("rst_if_valid",  bus.if_valid,      64'd1);
    chk("rst_full",      bus.tracker_full,  64'd0);
    chk("rst_underflow", bus.trk_underflow, 64'd0);

    // Sequential fetch, then a correctly predicted taken branch at 0x1004.
    drv(0, 0, 64'h0,    0, 0, 64'h0,    0, 64'h0);
    drv(0, 0, 64'h0,    0, 0, 64'h0,    1, 64'h2000);
    chk("seq_pc_target", bus.pc_if, 64'h2000);
    drv(0, 1, 64'h1000, 0, 0, 64'h0,    0, 64'h0);
    drv(0, 1, 64'h1004, 1, 1, 64'h2000, 0, 64'h0);
    // Prediction 0x2008 -> 0x2000 resolves to 0x3000: wrong target.
    drv(0, 0, 64'h0,    0, 0, 64'h0,    1, 64'h2000);
    drv(0, 1, 64'h2000, 0, 0, 64'h0,    0, 64'h0);
    drv(0, 1, 64'h2004, 0, 0, 64'h0,    0, 64'h0);
    drv(0, 1, 64'h2008, 1, 1, 64'h3000, 0, 64'h0);
    chk("wt_pc",       bus.pc_if,        64'h3000);
    chk("wt_bubble",   bus.if_valid,     64'd0);
    chk("wt_trk_full", bus.tracker_full, 64'd0);
    for (int i = 0; i < RCY; i++) drv(0, 0, 64'h0, 0, 0, 64'h0, 0, 64'h0);
    // Predicted-taken non-branch at 0x1010 -> redirect to 0x1014.
    drv(0, 0, 64'h0,    0, 0, 64'h0,    1, 64'h1010);
    drv(0, 1, 64'h3000, 1, 1, 64'h1010, 1, 64'h5000);
    drv(0, 1, 64'h1010, 0, 0, 64'h0,    0, 64'h0);
    chk("nb_pc", bus.pc_if, 64'h1014);
    for (int i = 0; i < RCY; i++) drv(0, 0, 64'h0, 0, 0, 64'h0, 0, 64'h0);
    // Fill the tracker: fetch stops and the PC freezes.
    repeat (6) drv(0, 0, 64'h0, 0, 0, 64'h0, 0, 64'h0);
    chk("full_flag",   bus.tracker_full, 64'd1);
    chk("full_nofetch", bus.if_valid,    64'd0);
    chk("full_pc",     bus.pc_if,        64'h1024);
    drv(0, 1, 64'h1014, 0, 0, 64'h0, 0, 64'h0);
    chk("full_resume", bus.if_valid, 64'd1);
    // Mispredict held off by stall, issued once stall drops.
    drv(1, 1, 64'h1018, 1, 1, 64'h7000, 0, 64'h0);
    drv(1, 1, 64'h1018, 1, 1, 64'h7000, 0, 64'h0);
    drv(0, 1, 64'h1018, 1, 1, 64'h7000, 0, 64'h0);
    chk("stall_redir_pc", bus.pc_if, 64'h7000);

    // Randomized traffic, biased toward predictions that resolve correctly.
    for (int i = 0; i < 3000; i++) begin
      pred_t       h;
      bit          st, ev, isj, j, bj;
      logic [63:0] px, tg, bt;
      st  = ($urandom % 8) == 0;
      ev  = (($urandom % 3) != 0) && (q.size() > 0 || ($urandom % 8) == 0);
      px  = {$urandom, $urandom} & ~64'h3;
      if (($urandom % 16) == 0) px = 64'hFFFF_FFFF_FFFF_FFFC;
      isj = $urandom % 2;
      j   = $urandom % 2;
      tg  = {$urandom, $urandom} & ~64'h3;
      if (q.size() > 0 && ($urandom % 4) != 0) begin
        h = q[0];
        if (h.pj) begin isj = 1; j = 1; tg = h.pt; end
        else j = 0;
      end
      bj = ($urandom % 4) == 0;
      bt = {$urandom, $urandom} & ~64'h3;
      drv(st, ev, px, isj, j, tg, bj, bt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
